wb_ram_slave: RTL and testbench
===============================

WB_RAM_SLAVE -- requirements
Module: wb_ram_slave

Interface
REQ-001 The block SHALL have parameter DEPTH_WORDS, default 1024, meaning number of 32-bit words, a power of two, minimum 4.
REQ-002 The block SHALL have parameter WAIT_STATES, default 1, meaning idle cycles inserted before each response, range 0..15.
REQ-003 The block SHALL have one clock and a synchronous, active-low reset.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock, rising edge.
REQ-005 The block SHALL have port rst, input, 1 bit: synchronous active-low reset.
REQ-006 The block SHALL have port cyc, input, 1 bit: Wishbone B4 bus cycle.
REQ-007 The block SHALL have port stb, input, 1 bit: Wishbone strobe.
REQ-008 The block SHALL have port we, input, 1 bit: write enable.
REQ-009 The block SHALL have port adr, input, 32 bits: byte address; adr[1:0] ignored.
REQ-010 The block SHALL have port dat_i, input, 32 bits: write data.
REQ-011 The block SHALL have port sel, input, 4 bits: byte lane selects; sel[0] maps to bits 7:0.
REQ-012 The block SHALL have port dat_o, output, 32 bits: read data.
REQ-013 The block SHALL have port ack, output, 1 bit: normal termination.
REQ-014 The block SHALL have port err, output, 1 bit: error termination; tied 0 when WB_RAM_ERR_EN is undefined.

Function
REQ-015 The block SHALL act as a Wishbone B4 classic responder to the core's instruction and data master ports.
REQ-016 The FSM SHALL have states IDLE, WAIT and RESP.
REQ-017 In IDLE, when cyc=1 and stb=1 at a rising edge, the block SHALL capture adr, we, dat_i and sel.
- Next state SHALL be WAIT if WAIT_STATES>0, else RESP.
REQ-018 WAIT SHALL last exactly WAIT_STATES cycles, counted by a 4-bit down-counter, then go to RESP.
REQ-019 If cyc=0 at any edge in WAIT, the block SHALL abort to IDLE with no memory write and no ack/err.
REQ-020 The memory access SHALL occur on the edge entering RESP.
- Write: only lanes with the captured sel bit set are updated.
- Read: the addressed word is loaded into dat_o.
REQ-021 ack (or err) SHALL be high for exactly one cycle, in RESP.
- Next state SHALL be IDLE unconditionally.
REQ-022 Latency SHALL be as follows: request sampled at edge N; ack high during cycle N+1+WAIT_STATES.
REQ-023 The minimum request-to-request spacing SHALL be 2+WAIT_STATES cycles; stb is not sampled outside IDLE.
REQ-024 On a write, dat_o SHALL hold its previous value.
REQ-025 ack and err SHALL never be high simultaneously.
REQ-026 A request with sel=0 SHALL be acked with no memory change.
REQ-027 Word index SHALL be adr[31:2].
- In-range means index < DEPTH_WORDS.

Reset
REQ-028 While rst=0 at an edge, the block SHALL force state=IDLE, counter=0, ack=0, err=0 and dat_o=0.
REQ-029 Reset asserted in WAIT SHALL discard the pending request; no write and no response are issued.
REQ-030 Memory array contents SHALL NOT be reset.
REQ-031 The first request SHALL be sampled no earlier than the first edge with rst=1.

Configuration
REQ-032 The feature SHALL be controlled by macro WB_RAM_ERR_EN.
REQ-033 When WB_RAM_ERR_EN is defined, an out-of-range index SHALL terminate with err=1 for one RESP cycle instead of ack.
- No write occurs.
- dat_o is unchanged.
REQ-034 When WB_RAM_ERR_EN is undefined, the index SHALL wrap modulo DEPTH_WORDS (low log2(DEPTH_WORDS) bits), always terminate with ack, and tie err to 0.

Verification
REQ-035 The bench SHALL cover: WAIT_STATES=1, write adr=0x10, dat_i=0xDEADBEEF, sel=0xF, then read adr=0x10 -> ack in cycle N+2 of each request, with read dat_o=0xDEADBEEF.
REQ-036 The bench SHALL cover: write 0x11223344 to adr=0x20, then write 0xAABBCCDD with sel=0x5, then read -> dat_o=0x11BB33DD.
REQ-037 The bench SHALL cover: WAIT_STATES=3, write adr=0x30, drop cyc after 1 wait cycle, then read 0x30 -> no ack for the aborted write, and old contents returned.
REQ-038 The bench SHALL cover: DEPTH_WORDS=1024, read adr=0x1004 -> with WB_RAM_ERR_EN, err=1 and ack=0 for one cycle; without it, ack=1 and the word at index 1 is returned.
REQ-039 The bench SHALL cover: rst=0 asserted in WAIT of a write to 0x40 -> ack=err=dat_o=0 the next cycle, and index 16 unchanged.
REQ-040 The bench SHALL cover: WAIT_STATES=0, stb held high for 4 cycles -> ack pulses in alternate cycles, with ack never high two cycles in a row.

Source files
------------

// File: rtl/wb_ram_slave.sv
// Wishbone B4 classic RAM responder with WAIT_STATES idle cycles before each response.
// Optional feature: define WB_RAM_ERR_EN to end out-of-range accesses with err instead of wrapping.
module wb_ram_slave #(
    parameter int DEPTH_WORDS = 1024,
    parameter int WAIT_STATES = 1
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        cyc,
    input  logic        stb,
    input  logic        we,
    input  logic [31:0] adr,
    input  logic [31:0] dat_i,
    input  logic [3:0]  sel,
    output logic [31:0] dat_o,
    output logic        ack,
    output logic        err,
    output logic [1:0]  dbg_state
);
    // Handshake: cyc&stb seen in IDLE is a request; it completes with exactly one
    // cycle of ack or err in RESP. stb is ignored in WAIT/RESP; dropping cyc in WAIT aborts.
    localparam int         AW = $clog2(DEPTH_WORDS);
    localparam logic [3:0] WS = 4'(WAIT_STATES);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    state_t      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] adr_q, adr_d;
    logic [31:0] wdat_q, wdat_d;
    logic [3:0]  sel_q, sel_d;
    logic        we_q, we_d;
    logic [31:0] dat_o_q, dat_o_d;
    logic        ack_q, ack_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH_WORDS];

    logic          acc_go;
    logic [31:0]   acc_adr;
    logic [31:0]   acc_dat;
    logic [3:0]    acc_sel;
    logic          acc_we;
    logic [AW-1:0] acc_idx;
    logic          mem_wr;
    logic          unused_bits;
`ifdef WB_RAM_ERR_EN
    logic          acc_oor;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        dat_o_d = dat_o_q;
        ack_d   = 1'b0;
        err_d   = 1'b0;
        acc_go  = 1'b0;
        acc_adr = adr_q;
        acc_dat = wdat_q;
        acc_sel = sel_q;
        acc_we  = we_q;

        case (state_q)
            IDLE: begin
                if (cyc && stb) begin
                    adr_d  = adr;
                    wdat_d = dat_i;
                    sel_d  = sel;
                    we_d   = we;
                    if (WS == 4'd0) begin
                        // No wait states: the access happens on the capture edge itself.
                        acc_go  = 1'b1;
                        acc_adr = adr;
                        acc_dat = dat_i;
                        acc_sel = sel;
                        acc_we  = we;
                        state_d = RESP;
                    end else begin
                        cnt_d   = WS;
                        state_d = WAIT;
                    end
                end
            end
            WAIT: begin
                if (!cyc) begin
                    cnt_d   = 4'd0;
                    state_d = IDLE;
                end else if (cnt_q == 4'd1) begin
                    acc_go  = 1'b1;
                    cnt_d   = 4'd0;
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP:    state_d = IDLE;
            default: state_d = IDLE;
        endcase

        acc_idx = acc_adr[AW+1:2];
        mem_wr  = 1'b0;
`ifdef WB_RAM_ERR_EN
        acc_oor = ({2'b00, acc_adr[31:2]} >= 32'(DEPTH_WORDS));
        if (acc_go) begin
            if (acc_oor) begin
                err_d = 1'b1;
            end else begin
                ack_d  = 1'b1;
                mem_wr = acc_we && rst;
                if (!acc_we) dat_o_d = mem[acc_idx];
            end
        end
`else
        if (acc_go) begin
            ack_d  = 1'b1;
            mem_wr = acc_we && rst;
            if (!acc_we) dat_o_d = mem[acc_idx];
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            dat_o_q <= 32'd0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            dat_o_q <= dat_o_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
        end
        adr_q  <= adr_d;
        wdat_q <= wdat_d;
        sel_q  <= sel_d;
        we_q   <= we_d;
    end

    // Array is deliberately not reset; only enabled byte lanes are written.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            for (int b = 0; b < 4; b++) begin
                if (acc_sel[b]) mem[acc_idx][8*b +: 8] <= acc_dat[8*b +: 8];
            end
        end
    end

    assign unused_bits = ^{acc_adr[1:0], acc_adr[31:AW+2]};

    assign dat_o     = dat_o_q;
    assign ack       = ack_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_ram_slave.sv
// Self-checking bench for wb_ram_slave: three instances with WAIT_STATES 0, 1 and 3
// checked against an associative-array memory model.
module tb_wb_ram_slave;
    localparam int DEPTH = 1024;

    logic        clk;
    logic        rst;
    logic        cyc   [3];
    logic        stb   [3];
    logic        we    [3];
    logic [31:0] adr   [3];
    logic [31:0] dat_i [3];
    logic [3:0]  sel   [3];
    logic [31:0] dat_o [3];
    logic        ack   [3];
    logic        err   [3];
    logic [1:0]  dbg_unused [3];

    int errors = 0;
    int checks = 0;

    logic [31:0] mdl [int];
    logic [31:0] exp_dato [3];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    wb_ram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(0)) u_ws0 (
        .clk(clk), .rst(rst), .cyc(cyc[0]), .stb(stb[0]), .we(we[0]), .adr(adr[0]),
        .dat_i(dat_i[0]), .sel(sel[0]), .dat_o(dat_o[0]), .ack(ack[0]), .err(err[0]),
        .dbg_state(dbg_unused[0]));
    wb_ram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(1)) u_ws1 (
        .clk(clk), .rst(rst), .cyc(cyc[1]), .stb(stb[1]), .we(we[1]), .adr(adr[1]),
        .dat_i(dat_i[1]), .sel(sel[1]), .dat_o(dat_o[1]), .ack(ack[1]), .err(err[1]),
        .dbg_state(dbg_unused[1]));
    wb_ram_slave #(.DEPTH_WORDS(DEPTH), .WAIT_STATES(3)) u_ws3 (
        .clk(clk), .rst(rst), .cyc(cyc[2]), .stb(stb[2]), .we(we[2]), .adr(adr[2]),
        .dat_i(dat_i[2]), .sel(sel[2]), .dat_o(dat_o[2]), .ack(ack[2]), .err(err[2]),
        .dbg_state(dbg_unused[2]));

    function automatic int ws_of(input int d);
        case (d)
            0:       return 0;
            1:       return 1;
            default: return 3;
        endcase
    endfunction

    // Reference: word index = adr/4; wraps modulo DEPTH, or errors out of range when enabled.
    task automatic model_access(input int d, input logic w, input logic [31:0] a,
                                input logic [31:0] wd, input logic [3:0] s,
                                output logic e_ack, output logic e_err, output logic [31:0] e_rd);
        int          idx;
        int          key;
        logic [31:0] word;
        idx = int'(a >> 2);
`ifdef WB_RAM_ERR_EN
        e_err = (idx >= DEPTH);
`else
        e_err = 1'b0;
        idx   = idx % DEPTH;
`endif
        e_ack = !e_err;
        e_rd  = exp_dato[d];
        if (e_ack) begin
            key = d * DEPTH + idx;
            if (w) begin
                word = mdl.exists(key) ? mdl[key] : 32'h0;
                for (int b = 0; b < 4; b++) if (s[b]) word[8*b +: 8] = wd[8*b +: 8];
                mdl[key] = word;
            end else begin
                e_rd = mdl.exists(key) ? mdl[key] : 32'hxxxxxxxx;
                exp_dato[d] = e_rd;
            end
        end
    endtask

    // Drives one request from an idle slave, returns what the bus showed; leaves the slave idle.
    task automatic xfer(input int d, input logic w, input logic [31:0] a, input logic [31:0] wd,
                        input logic [3:0] s, output logic got_ack, output logic got_err,
                        output int lat, output logic [31:0] rd, output logic both,
                        output logic lingering);
        cyc[d] = 1'b1; stb[d] = 1'b1; we[d] = w; adr[d] = a; dat_i[d] = wd; sel[d] = s;
        got_ack = 1'b0; got_err = 1'b0; lat = -1; rd = 32'h0; both = 1'b0; lingering = 1'b0;
        @(posedge clk); #1;
        for (int k = 0; k < 20; k++) begin
            if (ack[d] === 1'b1 && err[d] === 1'b1) both = 1'b1;
            if (ack[d] === 1'b1 || err[d] === 1'b1) begin
                got_ack = ack[d]; got_err = err[d]; lat = k; rd = dat_o[d];
                break;
            end
            @(posedge clk); #1;
        end
        cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
        @(posedge clk); #1;
        if (ack[d] !== 1'b0 || err[d] !== 1'b0) lingering = 1'b1;
    endtask

    task automatic test_reset();
        rst = 1'b0;
        for (int d = 0; d < 3; d++) begin
            cyc[d] = 1'b0; stb[d] = 1'b0; we[d] = 1'b0;
            adr[d] = 32'h0; dat_i[d] = 32'h0; sel[d] = 4'h0; exp_dato[d] = 32'h0;
        end
        repeat (3) @(posedge clk);
        #1;
        for (int d = 0; d < 3; d++) begin
            checks++;
            if (ack[d] !== 1'b0) begin errors++; $display("FAIL reset_ack[%0d]: got %b expected 0", d, ack[d]); end
            checks++;
            if (err[d] !== 1'b0) begin errors++; $display("FAIL reset_err[%0d]: got %b expected 0", d, err[d]); end
            checks++;
            if (dat_o[d] !== 32'h0) begin errors++; $display("FAIL reset_dat_o[%0d]: got %h expected 0", d, dat_o[d]); end
        end
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b1; adr[0] = 32'h0; dat_i[0] = 32'hCAFE0001; sel[0] = 4'hF;
        @(posedge clk); #1;
        checks++;
        if (ack[0] !== 1'b0) begin errors++; $display("FAIL req_in_reset_ack: got %b expected 0", ack[0]); end
        rst = 1'b1;
        @(posedge clk); #1;
        checks++;
        if (ack[0] !== 1'b1) begin errors++; $display("FAIL first_req_ack: got %b expected 1", ack[0]); end
        begin
            logic ea, ee; logic [31:0] er;
            model_access(0, 1'b1, 32'h0, 32'hCAFE0001, 4'hF, ea, ee, er);
        end
        cyc[0] = 1'b0; stb[0] = 1'b0; we[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_basic();
        logic ga, ge, b2, lg, ea, ee; int lat; logic [31:0] rd, er;
        model_access(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ea, ee, er);
        xfer(1, 1'b1, 32'h10, 32'hDEADBEEF, 4'hF, ga, ge, lat, rd, b2, lg);
        checks++;
        if (ga !== 1'b1) begin errors++; $display("FAIL basic_wr_ack: got %b expected 1", ga); end
        checks++;
        if (lat !== ws_of(1)) begin errors++; $display("FAIL basic_wr_latency: got %0d expected %0d", lat, ws_of(1)); end
        model_access(1, 1'b0, 32'h10, 32'h0, 4'hF, ea, ee, er);
        xfer(1, 1'b0, 32'h10, 32'h0, 4'hF, ga, ge, lat, rd, b2, lg);
        checks++;
        if (lat !== ws_of(1)) begin errors++; $display("FAIL basic_rd_latency: got %0d expected %0d", lat, ws_of(1)); end
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL basic_rd_data: got %h expected deadbeef", rd); end
        checks++;
        if (lg !== 1'b0) begin errors++; $display("FAIL basic_ack_one_cycle: got %b expected 0", lg); end
        model_access(1, 1'b1, 32'h14, 32'h01234567, 4'hF, ea, ee, er);
        xfer(1, 1'b1, 32'h14, 32'h01234567, 4'hF, ga, ge, lat, rd, b2, lg);
        checks++;
        if (rd !== 32'hDEADBEEF) begin errors++; $display("FAIL wr_holds_dat_o: got %h expected deadbeef", rd); end
    endtask

    task automatic test_byte_lanes();
        logic ga, ge, b2, lg, ea, ee; int lat; logic [31:0] rd, er;
        model_access(1, 1'b1, 32'h20, 32'h11223344, 4'hF, ea, ee, er);
        xfer(1, 1'b1, 32'h20, 32'h11223344, 4'hF, ga, ge, lat, rd, b2, lg);
        model_access(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, ea, ee, er);
        xfer(1, 1'b1, 32'h20, 32'hAABBCCDD, 4'h5, ga, ge, lat, rd, b2, lg);
        model_access(1, 1'b0, 32'h20, 32'h0, 4'hF, ea, ee, er);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, ga, ge, lat, rd, b2, lg);
        checks++;
        if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL byte_lane_merge: got %h expected 11bb33dd", rd); end
        model_access(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, ea, ee, er);
        xfer(1, 1'b1, 32'h20, 32'hFFFFFFFF, 4'h0, ga, ge, lat, rd, b2, lg);
        checks++;
        if (ga !== 1'b1) begin errors++; $display("FAIL sel0_ack: got %b expected 1", ga); end
        model_access(1, 1'b0, 32'h20, 32'h0, 4'hF, ea, ee, er);
        xfer(1, 1'b0, 32'h20, 32'h0, 4'hF, ga, ge, lat, rd, b2, lg);
        checks++;
        if (rd !== 32'h11BB33DD) begin errors++; $display("FAIL sel0_no_change: got %h expected 11bb33dd", rd); end
    endtask

    task automatic test_abort();
        logic ga, ge, b2, lg, ea, ee, seen; int lat; logic [31:0] rd, er;
        model_access(2, 1'b1, 32'h30, 32'h600DC0DE, 4'hF, ea, ee, er);
        xfer(2, 1'b1, 32'h30, 32'h600DC0DE, 4'hF, ga, ge, lat, rd, b2, lg);
        checks++;
        if (lat !== ws_of(2)) begin errors++; $display("FAIL ws3_latency: got %0d expected %0d", lat, ws_of(2)); end
        seen = 1'b0;
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h30; dat_i[2] = 32'hBAD0BAD0; sel[2] = 4'hF;
        @(posedge clk); #1;
        if (ack[2] === 1'b1 || err[2] === 1'b1) seen = 1'b1;
        @(posedge clk); #1;
        if (ack[2] === 1'b1 || err[2] === 1'b1) seen = 1'b1;
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        repeat (6) begin
            @(posedge clk); #1;
            if (ack[2] === 1'b1 || err[2] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL abort_no_termination: got %b expected 0", seen); end
        model_access(2, 1'b0, 32'h30, 32'h0, 4'hF, ea, ee, er);
        xfer(2, 1'b0, 32'h30, 32'h0, 4'hF, ga, ge, lat, rd, b2, lg);
        checks++;
        if (rd !== 32'h600DC0DE) begin errors++; $display("FAIL abort_no_write: got %h expected 600dc0de", rd); end
    endtask

    task automatic test_range();
        logic ga, ge, b2, lg, ea, ee; int lat; logic [31:0] rd, er;
        model_access(1, 1'b1, 32'h4, 32'h0BADF00D, 4'hF, ea, ee, er);
        xfer(1, 1'b1, 32'h4, 32'h0BADF00D, 4'hF, ga, ge, lat, rd, b2, lg);
        model_access(1, 1'b0, 32'h1004, 32'h0, 4'hF, ea, ee, er);
        xfer(1, 1'b0, 32'h1004, 32'h0, 4'hF, ga, ge, lat, rd, b2, lg);
        checks++;
        if (ga !== ea) begin errors++; $display("FAIL range_rd_ack: got %b expected %b", ga, ea); end
        checks++;
        if (ge !== ee) begin errors++; $display("FAIL range_rd_err: got %b expected %b", ge, ee); end
        checks++;
        if (rd !== er) begin errors++; $display("FAIL range_rd_data: got %h expected %h", rd, er); end
        checks++;
        if (lg !== 1'b0 || b2 !== 1'b0) begin errors++; $display("FAIL range_term_pulse: got %b%b expected 00", lg, b2); end
        model_access(1, 1'b1, 32'h1004, 32'h5A5A5A5A, 4'hF, ea, ee, er);
        xfer(1, 1'b1, 32'h1004, 32'h5A5A5A5A, 4'hF, ga, ge, lat, rd, b2, lg);
        checks++;
        if (ge !== ee) begin errors++; $display("FAIL range_wr_err: got %b expected %b", ge, ee); end
        model_access(1, 1'b0, 32'h4, 32'h0, 4'hF, ea, ee, er);
        xfer(1, 1'b0, 32'h4, 32'h0, 4'hF, ga, ge, lat, rd, b2, lg);
        checks++;
        if (rd !== er) begin errors++; $display("FAIL range_wr_effect: got %h expected %h", rd, er); end
    endtask

    task automatic test_reset_in_wait();
        logic ga, ge, b2, lg, ea, ee, seen; int lat; logic [31:0] rd, er;
        model_access(2, 1'b1, 32'h40, 32'h13579BDF, 4'hF, ea, ee, er);
        xfer(2, 1'b1, 32'h40, 32'h13579BDF, 4'hF, ga, ge, lat, rd, b2, lg);
        cyc[2] = 1'b1; stb[2] = 1'b1; we[2] = 1'b1; adr[2] = 32'h40; dat_i[2] = 32'hFFFF0000; sel[2] = 4'hF;
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        checks++;
        if (ack[2] !== 1'b0) begin errors++; $display("FAIL rst_wait_ack: got %b expected 0", ack[2]); end
        checks++;
        if (err[2] !== 1'b0) begin errors++; $display("FAIL rst_wait_err: got %b expected 0", err[2]); end
        checks++;
        if (dat_o[2] !== 32'h0) begin errors++; $display("FAIL rst_wait_dat_o: got %h expected 0", dat_o[2]); end
        rst = 1'b1;
        cyc[2] = 1'b0; stb[2] = 1'b0; we[2] = 1'b0;
        for (int d = 0; d < 3; d++) exp_dato[d] = 32'h0;
        seen = 1'b0;
        repeat (5) begin
            @(posedge clk); #1;
            if (ack[2] === 1'b1 || err[2] === 1'b1) seen = 1'b1;
        end
        checks++;
        if (seen !== 1'b0) begin errors++; $display("FAIL rst_wait_no_resp: got %b expected 0", seen); end
        model_access(2, 1'b0, 32'h40, 32'h0, 4'hF, ea, ee, er);
        xfer(2, 1'b0, 32'h40, 32'h0, 4'hF, ga, ge, lat, rd, b2, lg);
        checks++;
        if (rd !== 32'h13579BDF) begin errors++; $display("FAIL rst_wait_no_write: got %h expected 13579bdf", rd); end
    endtask

    task automatic test_back_to_back();
        logic ga, ge, b2, lg, ea, ee, prev; int lat, next_hit; logic [31:0] rd, er;
        model_access(0, 1'b1, 32'h8, 32'h24681357, 4'hF, ea, ee, er);
        xfer(0, 1'b1, 32'h8, 32'h24681357, 4'hF, ga, ge, lat, rd, b2, lg);
        checks++;
        if (lat !== 0) begin errors++; $display("FAIL ws0_latency: got %0d expected 0", lat); end
        cyc[0] = 1'b1; stb[0] = 1'b1; we[0] = 1'b0; adr[0] = 32'h8; sel[0] = 4'hF;
        next_hit = 1;
        prev = 1'b0;
        for (int k = 1; k <= 4; k++) begin
            @(posedge clk); #1;
            checks++;
            if (ack[0] !== (k == next_hit)) begin
                errors++; $display("FAIL b2b_ack_cycle%0d: got %b expected %b", k, ack[0], (k == next_hit));
            end
            if (k == next_hit) begin
                model_access(0, 1'b0, 32'h8, 32'h0, 4'hF, ea, ee, er);
                next_hit = k + 2;
                checks++;
                if (dat_o[0] !== er) begin errors++; $display("FAIL b2b_data%0d: got %h expected %h", k, dat_o[0], er); end
            end
            checks++;
            if (prev === 1'b1 && ack[0] === 1'b1) begin errors++; $display("FAIL b2b_consecutive%0d: got 11 expected 10", k); end
            prev = ack[0];
        end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_random();
        logic ga, ge, b2, lg, ea, ee, w; int lat, idx; logic [31:0] rd, er, a, wd; logic [3:0] s;
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 32; i++) begin
                wd = $urandom;
                model_access(d, 1'b1, 32'(i) << 2, wd, 4'hF, ea, ee, er);
                xfer(d, 1'b1, 32'(i) << 2, wd, 4'hF, ga, ge, lat, rd, b2, lg);
                checks++;
                if (ga !== 1'b1) begin errors++; $display("FAIL init_ack[%0d][%0d]: got %b expected 1", d, i, ga); end
            end
        end
        for (int d = 0; d < 3; d++) begin
            for (int i = 0; i < 40; i++) begin
                w   = 1'($urandom_range(1, 0));
                idx = int'($urandom_range(31, 0));
                if ($urandom_range(7, 0) == 0) idx = idx + DEPTH;
                a   = (32'(idx) << 2) | 32'($urandom_range(3, 0));
                wd  = $urandom;
                s   = 4'($urandom_range(15, 0));
                model_access(d, w, a, wd, s, ea, ee, er);
                xfer(d, w, a, wd, s, ga, ge, lat, rd, b2, lg);
                checks++;
                if (ga !== ea) begin errors++; $display("FAIL rnd_ack[%0d] adr=%h: got %b expected %b", d, a, ga, ea); end
                checks++;
                if (ge !== ee) begin errors++; $display("FAIL rnd_err[%0d] adr=%h: got %b expected %b", d, a, ge, ee); end
                checks++;
                if (lat !== ws_of(d)) begin errors++; $display("FAIL rnd_latency[%0d]: got %0d expected %0d", d, lat, ws_of(d)); end
                checks++;
                if (rd !== er) begin errors++; $display("FAIL rnd_dat_o[%0d] adr=%h we=%b: got %h expected %h", d, a, w, rd, er); end
                checks++;
                if (b2 !== 1'b0 || lg !== 1'b0) begin errors++; $display("FAIL rnd_pulse[%0d]: got %b%b expected 00", d, b2, lg); end
            end
        end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_basic();
        test_byte_lanes();
        test_abort();
        test_range();
        test_reset_in_wait();
        test_back_to_back();
        test_random();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
